dpd_delay_est: RTL

DPD_DELAY_EST -- requirements
Module: dpd_delay_est

---
 rtl/dpd_delay_est.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/dpd_delay_est.sv
`default_nettype none
// ============================================================================
//  Module      : dpd_delay_est
//  Description : DPD loop-delay estimator. Sign-correlates the feedback
//                signal against a delayed copy of the reference for every
//                candidate lag in parallel, then serially picks the best lag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpd_delay_est #(
    parameter int MAX_LAG  = 64,
    parameter int N_CORR   = 256,
    parameter int MIN_PEAK = 320
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [19:0]            sig_ref_i,
    input  logic signed [19:0]            sig_ref_q,
    input  logic signed [19:0]            sig_fb_i,
    input  logic signed [19:0]            sig_fb_q,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(MAX_LAG)-1:0]    lag,
    output logic [$clog2(2*N_CORR):0]     peak,
    output logic                          lock
);

    localparam int c_lag_w = $clog2(MAX_LAG);
    localparam int c_acc_w = $clog2(2*N_CORR) + 1;
    localparam int c_cnt_w = $clog2(N_CORR + MAX_LAG);

    localparam logic [c_cnt_w-1:0] c_fill_cnt = c_cnt_w'(MAX_LAG - 2);
    localparam logic [c_cnt_w-1:0] c_acc_cnt  = c_cnt_w'(N_CORR - 1);
    localparam logic [c_lag_w-1:0] c_last_lag = c_lag_w'(MAX_LAG - 1);
    localparam logic [31:0]        c_min_peak = 32'(MIN_PEAK);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fill   = 3'd1;
    localparam logic [2:0] c_st_acc    = 3'd2;
    localparam logic [2:0] c_st_search = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_lag_w-1:0] r_idx;
    logic [c_acc_w-1:0] r_max;
    logic [c_lag_w-1:0] r_max_lag;
    logic [c_acc_w-1:0] w_sel;
    logic [c_acc_w-1:0] w_max_nxt;
    logic [c_lag_w-1:0] w_lag_nxt;
    logic               w_clear;

    // Only the sign bits take part in the correlation.
    logic r_ref_si, r_ref_sq, r_fb_si, r_fb_sq;
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{sig_ref_i[18:0], sig_ref_q[18:0], sig_fb_i[18:0], sig_fb_q[18:0]};

    always_ff @(posedge clk) begin
        r_ref_si <= sig_ref_i[19];
        r_ref_sq <= sig_ref_q[19];
        r_fb_si  <= sig_fb_i[19];
        r_fb_sq  <= sig_fb_q[19];
    end

    // Entry 0 is the input register itself; r_sr[k] holds ref[n-k-1].
    logic [1:0] r_sr [MAX_LAG-1];
    logic [1:0] w_hist [MAX_LAG];

    always_ff @(posedge clk) begin
        r_sr[0] <= {r_ref_si, r_ref_sq};
        for (int k = 1; k < MAX_LAG - 1; k++) begin
            r_sr[k] <= r_sr[k-1];
        end
    end

    always_comb begin
        w_hist[0] = {r_ref_si, r_ref_sq};
        for (int l = 1; l < MAX_LAG; l++) begin
            w_hist[l] = r_sr[l-1];
        end
    end

    logic [1:0]         w_match [MAX_LAG];
    logic [c_acc_w-1:0] r_acc   [MAX_LAG];

    always_comb begin
        for (int l = 0; l < MAX_LAG; l++) begin
            w_match[l] = {1'b0, ~(w_hist[l][1] ^ r_fb_si)} + {1'b0, ~(w_hist[l][0] ^ r_fb_sq)};
        end
    end

    assign w_clear = (r_state == c_st_idle) && start;

    always_ff @(posedge clk) begin
        for (int l = 0; l < MAX_LAG; l++) begin
            if (w_clear) begin
                r_acc[l] <= '0;
            end else if (r_state == c_st_acc) begin
                r_acc[l] <= r_acc[l] + c_acc_w'(w_match[l]);
            end
        end
    end

    // Strictly-greater update keeps the lowest lag on a tie.
    always_comb begin
        w_sel     = r_acc[r_idx];
        w_max_nxt = r_max;
        w_lag_nxt = r_max_lag;
        if (w_sel > r_max) begin
            w_max_nxt = w_sel;
            w_lag_nxt = r_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_fill;
                end
            end
            c_st_fill: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_acc;
                end
            end
            c_st_acc: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_search;
                end
            end
            c_st_search: begin
                busy = 1'b1;
                if (r_idx == c_last_lag) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                done        = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Results are loaded on the last search edge so they are valid with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_max     <= '0;
            r_max_lag <= '0;
            lag       <= '0;
            peak      <= '0;
            lock      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_cnt <= c_fill_cnt;
                    end
                end
                c_st_fill: begin
                    r_cnt <= (r_cnt == '0) ? c_acc_cnt : r_cnt - c_cnt_w'(1);
                end
                c_st_acc: begin
                    r_cnt     <= r_cnt - c_cnt_w'(1);
                    r_idx     <= '0;
                    r_max     <= '0;
                    r_max_lag <= '0;
                end
                c_st_search: begin
                    r_idx     <= r_idx + c_lag_w'(1);
                    r_max     <= w_max_nxt;
                    r_max_lag <= w_lag_nxt;
                    if (r_idx == c_last_lag) begin
                        lag  <= w_lag_nxt;
                        peak <= w_max_nxt;
                        lock <= (32'(w_max_nxt) >= c_min_peak);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
